// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus transmit path: opcode encodings,
// register-index / opcode widths and the register-write opcode decode.
// Imported by cdb_broadcaster and rr_arbiter users.
package cdb_pkg;

  localparam int REG_W     = 3;  // architectural register index width
  localparam int OP_W      = 4;  // opcode = instruction bits [3:0]
  localparam int TAG_W_DEF = 3;  // default reservation-station tag width

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0100;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0101;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [OP_W-1:0]  opcode_t;

  // Per-result routing metadata held alongside the data in each slot.
  typedef struct packed {
    reg_idx_t dest;
    opcode_t  op;
  } cdb_meta_t;

  // Only the arithmetic ops write the register file; everything else just
  // wakes the waiting reservation stations through the tag.
  function automatic logic is_reg_write(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr_i (mod N).
// Latency: purely combinational. Backpressure: none, caller owns the pointer.
// Ports: req_i request vector, ptr_i search start, grant_o one-hot winner,
//        vld_o any grant, idx_o winner index, ptr_nxt_o pointer after this cycle.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic             vld_o,
  output logic [PTR_W-1:0] idx_o,
  output logic [PTR_W-1:0] ptr_nxt_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] pos;
  logic [PTR_W:0]   nxt;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int off = 0; off < N; off++) begin
      // One extra bit so ptr+off can be folded back below N without overflow.
      sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      pos = sum[PTR_W-1:0];
      if (!found && req_i[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
    vld_o = found;
  end

  always_comb begin
    nxt = {1'b0, idx_o} + (PTR_W+1)'(1);
    if (nxt == (PTR_W+1)'(N)) nxt = '0;
    ptr_nxt_o = found ? nxt[PTR_W-1:0] : ptr_i;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: one-deep slot per FU, round-robin grant, registered beat.
// Latency: accept at edge k -> cdb_done after edge k+1 (uncontended).
// Backpressure: req_ready[i] low while slot i is full and not being granted.
// Ports: clock/reset (sync, active-high); req_* per-FU result inputs packed
//        FU i at [i*W +: W]; cdb_* broadcast beat; cdb_wen register-file write.
// Optional: CDB_STALL_COUNT_EN adds stall_cnt, saturating count of cycles in
//        which a held result waited without being granted.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int N_FU   = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int RTZ    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_FU-1:0]          req_valid,
  output logic [N_FU-1:0]          req_ready,
  input  logic [N_FU*DATA_W-1:0]   req_data,
  input  logic [N_FU*TAG_W-1:0]    req_tag,
  input  logic [N_FU*REG_W-1:0]    req_dest,
  input  logic [N_FU*OP_W-1:0]     req_op,
  output logic                     cdb_done,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [REG_W-1:0]         cdb_dest,
  output logic [OP_W-1:0]          cdb_op,
  output logic                     cdb_wen
`ifdef CDB_STALL_COUNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [N_FU-1:0]   full_q, full_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              idle_q, idle_d;
  logic [N_FU-1:0]   eligible, grant, accept;
  logic              win_vld;
  logic [PTR_W-1:0]  win_idx;

  logic [DATA_W-1:0] slot_data_q [N_FU];
  logic [TAG_W-1:0]  slot_tag_q  [N_FU];
  cdb_meta_t         slot_meta_q [N_FU];

  logic              done_q;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  tag_q;
  cdb_meta_t         meta_q;

  // The idle cycle after each beat blocks every slot, which is what gives
  // edge-triggered consumers a low phase on cdb_done.
  assign eligible = full_q & {N_FU{~idle_q}};

  rr_arbiter #(.N(N_FU), .PTR_W(PTR_W)) u_arb (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .vld_o     (win_vld),
    .idx_o     (win_idx),
    .ptr_nxt_o (ptr_d)
  );

  // A slot being drained this cycle can take a new result on the same edge.
  assign req_ready = {N_FU{~reset}} & (~full_q | grant);
  assign accept    = req_valid & req_ready;
  assign full_d    = accept | (full_q & ~grant);
  assign idle_d    = (RTZ != 0) ? win_vld : 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= '0;
      ptr_q  <= '0;
      idle_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
      meta_q <= '0;
    end else begin
      full_q <= full_d;
      ptr_q  <= ptr_d;
      idle_q <= idle_d;
      done_q <= win_vld;
      if (win_vld) begin
        data_q <= slot_data_q[win_idx];
        tag_q  <= slot_tag_q[win_idx];
        meta_q <= slot_meta_q[win_idx];
      end
    end
  end

  // Slot payloads need no reset: full_q alone says whether they are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_FU; i++) begin
      if (accept[i]) begin
        slot_data_q[i] <= req_data[i*DATA_W +: DATA_W];
        slot_tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
        slot_meta_q[i] <= '{dest: req_dest[i*REG_W +: REG_W],
                            op:   req_op[i*OP_W +: OP_W]};
      end
    end
  end

  assign cdb_done = done_q;
  assign cdb_data = data_q;
  assign cdb_tag  = tag_q;
  assign cdb_dest = meta_q.dest;
  assign cdb_op   = meta_q.op;
  // Register 0 is never written; non-arithmetic ops only wake the RS.
  assign cdb_wen  = done_q && (meta_q.dest != '0) && is_reg_write(meta_q.op);

`ifdef CDB_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (|(full_q & ~grant) && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: an RTZ=1 instance (dut0) and an RTZ=0 instance
// (dut1) share the request payload buses but have separate valids.
module tb_cdb_broadcaster;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 3;

  logic            clock, reset;
  logic [N-1:0]    vld0, vld1, rdy0, rdy1;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [N*3-1:0]  req_dest;
  logic [N*4-1:0]  req_op;

  logic          done0, wen0, done1, wen1;
  logic [DW-1:0] data0, data1;
  logic [TW-1:0] tag0, tag1;
  logic [2:0]    dest0, dest1;
  logic [3:0]    op0, op1;
`ifdef CDB_STALL_COUNT_EN
  logic [15:0]   stall0, stall1;
`endif

  cdb_broadcaster #(.N_FU(N), .DATA_W(DW), .TAG_W(TW), .RTZ(1)) dut0 (
    .clock(clock), .reset(reset), .req_valid(vld0), .req_ready(rdy0),
    .req_data(req_data), .req_tag(req_tag), .req_dest(req_dest), .req_op(req_op),
    .cdb_done(done0), .cdb_data(data0), .cdb_tag(tag0), .cdb_dest(dest0),
    .cdb_op(op0), .cdb_wen(wen0)
`ifdef CDB_STALL_COUNT_EN
    , .stall_cnt(stall0)
`endif
  );

  cdb_broadcaster #(.N_FU(N), .DATA_W(DW), .TAG_W(TW), .RTZ(0)) dut1 (
    .clock(clock), .reset(reset), .req_valid(vld1), .req_ready(rdy1),
    .req_data(req_data), .req_tag(req_tag), .req_dest(req_dest), .req_op(req_op),
    .cdb_done(done1), .cdb_data(data1), .cdb_tag(tag1), .cdb_dest(dest1),
    .cdb_op(op1), .cdb_wen(wen1)
`ifdef CDB_STALL_COUNT_EN
    , .stall_cnt(stall1)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  tag;
    logic [2:0]  dest;
    logic [3:0]  op;
    logic        wen;
  } beat_t;

  typedef struct {
    int    fu;
    beat_t b;
  } vec_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t e0, e1;
  int    n_checks = 0;
  int    n_err    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int fu, input beat_t b);
    req_data[fu*DW +: DW] = b.data;
    req_tag[fu*TW +: TW]  = b.tag;
    req_dest[fu*3 +: 3]   = b.dest;
    req_op[fu*4 +: 4]     = b.op;
  endtask

  // Scoreboards: every beat seen on the bus must match the head of its queue.
  always @(negedge clock) begin
    if (!reset && done0) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL dut0_beat: got unexpected beat data=%0h expected none", data0);
      end else begin
        e0 = q0.pop_front();
        check("dut0_data", 32'(data0), 32'(e0.data));
        check("dut0_tag",  32'(tag0),  32'(e0.tag));
        check("dut0_dest", 32'(dest0), 32'(e0.dest));
        check("dut0_op",   32'(op0),   32'(e0.op));
        check("dut0_wen",  32'(wen0),  32'(e0.wen));
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL dut1_beat: got unexpected beat data=%0h expected none", data1);
      end else begin
        e1 = q1.pop_front();
        check("dut1_data", 32'(data1), 32'(e1.data));
        check("dut1_tag",  32'(tag1),  32'(e1.tag));
        check("dut1_dest", 32'(dest1), 32'(e1.dest));
        check("dut1_op",   32'(op1),   32'(e1.op));
        check("dut1_wen",  32'(wen1),  32'(e1.wen));
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[8];
    logic [3:0]  exp_rdy[7];
    beat_t       b, b2;

    vt[0] = '{0, '{16'h1234, 3'd2, 3'd3, 4'b0000, 1'b1}};
    vt[1] = '{1, '{16'hABCD, 3'd5, 3'd5, 4'b0010, 1'b0}};
    vt[2] = '{2, '{16'h0F0F, 3'd1, 3'd0, 4'b0000, 1'b0}};
    vt[3] = '{3, '{16'h5555, 3'd7, 3'd7, 4'b0100, 1'b1}};
    vt[4] = '{1, '{16'h8001, 3'd3, 3'd1, 4'b0101, 1'b1}};
    vt[5] = '{2, '{16'h7FFF, 3'd4, 3'd6, 4'b0001, 1'b1}};
    vt[6] = '{0, '{16'hFFFF, 3'd0, 3'd2, 4'b1111, 1'b0}};
    vt[7] = '{3, '{16'h0000, 3'd6, 3'd4, 4'b0110, 1'b0}};

    // Contention on dut0: each grant frees its slot, the idle cycle keeps it.
    exp_rdy = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111};

    reset = 1'b1; vld0 = '0; vld1 = '0;
    req_data = '0; req_tag = '0; req_dest = '0; req_op = '0;

    // ---- reset state ----
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready0", 32'(rdy0), 0);
    check("rst_ready1", 32'(rdy1), 0);
    check("rst_done",   32'(done0), 0);
    check("rst_data",   32'(data0), 0);
    check("rst_tag",    32'(tag0), 0);
    check("rst_dest",   32'(dest0), 0);
    check("rst_op",     32'(op0), 0);
    check("rst_wen",    32'(wen0), 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(rdy0), 32'hF);

    // ---- table-driven single results, one-cycle latency ----
    for (int v = 0; v < 8; v++) begin
      @(posedge clock); #1;
      drive(vt[v].fu, vt[v].b);
      vld0[vt[v].fu] = 1'b1;
      q0.push_back(vt[v].b);
      #1 check("vec_ready", 32'(rdy0[vt[v].fu]), 1);
      @(posedge clock); #1 vld0 = '0;
      @(negedge clock) check("vec_lat_early", 32'(done0), 0);
      @(negedge clock) check("vec_lat_done", 32'(done0), 1);
      repeat (2) @(posedge clock);
    end

    // ---- contention, RTZ=1: in-order, one done-low cycle between beats ----
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      b = '{16'(16'h10 + i), 3'(i), 3'(i + 1), 4'b0000, 1'b1};
      drive(i, b);
      q0.push_back(b);
    end
    vld0 = 4'hF;
    @(posedge clock); #1 vld0 = '0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clock);
      check("contend_ready", 32'(rdy0), 32'(exp_rdy[j]));
      check("contend_done",  32'(done0), 32'(j % 2));
    end
    @(negedge clock);
    check("contend_last_done", 32'(done0), 1);
    check("contend_ready_final", 32'(rdy0), 32'hF);
    repeat (2) @(posedge clock);

    // ---- round-robin wrap: move ptr to 3, then FU3 beats FU0 ----
    @(posedge clock); #1;
    b = '{16'h0022, 3'd2, 3'd2, 4'b0000, 1'b1}; drive(2, b); q0.push_back(b);
    vld0 = 4'b0100;
    @(posedge clock); #1 vld0 = '0;
    repeat (4) @(posedge clock);
    #1;
    b  = '{16'h0033, 3'd3, 3'd3, 4'b0001, 1'b1}; drive(3, b);
    b2 = '{16'h0030, 3'd0, 3'd1, 4'b0100, 1'b1}; drive(0, b2);
    q0.push_back(b); q0.push_back(b2);
    vld0 = 4'b1001;
    @(posedge clock); #1 vld0 = '0;
    repeat (6) @(posedge clock);
    // ptr should now be 1, so FU1 outranks FU0.
    #1;
    b  = '{16'h0041, 3'd1, 3'd4, 4'b0000, 1'b1}; drive(1, b);
    b2 = '{16'h0040, 3'd0, 3'd5, 4'b0000, 1'b1}; drive(0, b2);
    q0.push_back(b); q0.push_back(b2);
    vld0 = 4'b0011;
    @(posedge clock); #1 vld0 = '0;
    repeat (6) @(posedge clock);
    check("rr_drained", 32'(q0.size()), 0);

    // ---- reset mid-operation: held results are dropped ----
    @(posedge clock); #1;
    drive(0, '{16'hDEAD, 3'd1, 3'd1, 4'b0000, 1'b1});
    drive(1, '{16'hBEEF, 3'd2, 3'd2, 4'b0000, 1'b1});
    drive(3, '{16'hCAFE, 3'd3, 3'd3, 4'b0000, 1'b1});
    vld0 = 4'b1011;
    @(posedge clock); #1 vld0 = '0; reset = 1'b1;
    @(negedge clock) check("midrst_ready_low", 32'(rdy0), 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("midrst_data", 32'(data0), 0);
    check("midrst_tag",  32'(tag0), 0);
    check("midrst_dest", 32'(dest0), 0);
    check("midrst_op",   32'(op0), 0);
    check("midrst_wen",  32'(wen0), 0);
    check("midrst_ready", 32'(rdy0), 32'hF);
`ifdef CDB_STALL_COUNT_EN
    check("midrst_stall", 32'(stall0), 0);
`endif
    for (int j = 0; j < 4; j++) begin
      @(negedge clock) check("midrst_no_done", 32'(done0), 0);
    end
    // ptr back at 0: FU0 must beat FU3.
    @(posedge clock); #1;
    b  = '{16'h00A0, 3'd4, 3'd6, 4'b0000, 1'b1}; drive(0, b);
    b2 = '{16'h00A3, 3'd5, 3'd7, 4'b0101, 1'b1}; drive(3, b2);
    q0.push_back(b); q0.push_back(b2);
    vld0 = 4'b1001;
    @(posedge clock); #1 vld0 = '0;
    repeat (5) @(posedge clock);
    #1;
    b = '{16'h2222, 3'd6, 3'd2, 4'b0000, 1'b1}; drive(2, b); q0.push_back(b);
    vld0 = 4'b0100;
    @(posedge clock); #1 vld0 = '0;
    repeat (4) @(posedge clock);

    // ---- RTZ=0 back-to-back on dut1 ----
    @(posedge clock); #1;
    b  = '{16'h05A0, 3'd0, 3'd3, 4'b0000, 1'b1}; drive(0, b);
    b2 = '{16'h05A1, 3'd1, 3'd4, 4'b0011, 1'b0}; drive(1, b2);
    q1.push_back(b); q1.push_back(b2);
    vld1 = 4'b0011;
    @(posedge clock); #1 vld1 = '0;
    @(negedge clock) check("b2b_done_k0", 32'(done1), 0);
    @(negedge clock) check("b2b_done_k1", 32'(done1), 1);
    @(negedge clock) check("b2b_done_k2", 32'(done1), 1);
    @(negedge clock) check("b2b_done_k3", 32'(done1), 0);
`ifdef CDB_STALL_COUNT_EN
    check("b2b_stall_cnt", 32'(stall1), 1);
`endif

    repeat (4) @(posedge clock);
    check("final_q0_empty", 32'(q0.size()), 0);
    check("final_q1_empty", 32'(q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
